// File: rtl/ysyx_23060332_ifu_pkg.sv
// Shared IFU definitions for the NPC core.
// State encodings are one-hot so that valid outputs decode glitch-free.
package ysyx_23060332_ifu_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;

    localparam logic [ADDR_W-1:0] RESET_PC_DEF = 32'h8000_0000;
    localparam logic [INST_W-1:0] INST_NOP     = 32'h0000_0013;

    typedef enum logic [4:0] {
        IFU_IDLE = 5'b00001,
        IFU_REQ  = 5'b00010,
        IFU_WAIT = 5'b00100,
        IFU_OUT  = 5'b01000,
        IFU_ERR  = 5'b10000
    } ifu_state_e;

    function automatic logic misaligned(input logic [ADDR_W-1:0] a);
        return a[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_23060332_pc_reg.sv
// Program counter: reset value, +4 advance, redirect load.
// Flags a redirect whose target is not word aligned.
module ysyx_23060332_pc_reg
    import ysyx_23060332_ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        adv_i,
    input  logic        load_i,
    input  logic [31:0] load_addr_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_d_o,
    output logic        misalign_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    // Redirect wins over sequential advance; +4 wraps modulo 2^32.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_addr_i;
        end else if (adv_i) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o       = pc_q;
    assign pc_d_o     = pc_d;
    assign misalign_o = load_i & misaligned(load_addr_i);

endmodule

// File: rtl/ysyx_23060332_ifu.sv
// Instruction fetch unit: PC ownership, imem request/response,
// valid/ready hand-off to decode and EXU redirect handling.
module ysyx_23060332_ifu
    import ysyx_23060332_ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        jump_flag,
    input  logic [31:0] jump_addr,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr,
    output logic        fetch_err
);

    ifu_state_e  state_q, state_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_addr_q, inst_addr_d;
    logic        drop_q, drop_d;
    logic        err_q, err_d;

    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        pc_adv;
    logic        pc_load;
    logic        misalign;
    logic        active;

    assign active  = (state_q == IFU_REQ) || (state_q == IFU_WAIT)
                  || (state_q == IFU_OUT);
    assign pc_load = jump_flag & active;
    assign pc_adv  = (state_q == IFU_OUT) & inst_ready & ~jump_flag;

    ysyx_23060332_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .adv_i       (pc_adv),
        .load_i      (pc_load),
        .load_addr_i (jump_addr),
        .pc_o        (pc),
        .pc_d_o      (pc_next),
        .misalign_o  (misalign)
    );

    always_comb begin
        state_d     = state_q;
        req_addr_d  = req_addr_q;
        inst_d      = inst_q;
        inst_addr_d = inst_addr_q;
        drop_d      = drop_q;
        unique case (state_q)
            IFU_IDLE: begin
                state_d    = IFU_REQ;
                req_addr_d = pc;
            end
            IFU_REQ: begin
                if (misalign) begin
                    state_d = IFU_ERR;
                end else begin
                    if (jump_flag) begin
                        drop_d = 1'b1;
                    end
                    if (imem_req_ready) begin
                        state_d = IFU_WAIT;
                    end
                end
            end
            IFU_WAIT: begin
                // A redirect arriving with the response also kills it.
                if (misalign) begin
                    state_d = IFU_ERR;
                end else if (imem_rsp_valid) begin
                    if (drop_q || jump_flag) begin
                        drop_d     = 1'b0;
                        req_addr_d = pc_next;
                        state_d    = IFU_REQ;
                    end else if (imem_rsp_err) begin
                        state_d = IFU_ERR;
                    end else begin
                        inst_d      = imem_rsp_data;
                        inst_addr_d = req_addr_q;
                        state_d     = IFU_OUT;
                    end
                end else if (jump_flag) begin
                    drop_d = 1'b1;
                end
            end
            IFU_OUT: begin
                if (misalign) begin
                    state_d = IFU_ERR;
                end else if (inst_ready || jump_flag) begin
                    req_addr_d = pc_next;
                    state_d    = IFU_REQ;
                end
            end
            IFU_ERR: begin
                state_d = IFU_ERR;
            end
            default: begin
                state_d = IFU_IDLE;
            end
        endcase
        err_d = err_q | (state_d == IFU_ERR);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IFU_IDLE;
            req_addr_q  <= RESET_PC;
            inst_q      <= INST_NOP;
            inst_addr_q <= RESET_PC;
            drop_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_addr_q  <= req_addr_d;
            inst_q      <= inst_d;
            inst_addr_q <= inst_addr_d;
            drop_q      <= drop_d;
            err_q       <= err_d;
        end
    end

    assign imem_req_valid = (state_q == IFU_REQ);
    assign inst_valid     = (state_q == IFU_OUT);
    assign imem_req_addr  = req_addr_q;
    assign inst_o         = inst_q;
    assign inst_addr      = inst_addr_q;
    assign fetch_err      = err_q;

endmodule

// File: tb/tb_ysyx_23060332_ifu.sv
// Directed bench for the IFU: fetch timing, back-pressure, redirects,
// faults and PC wrap-around.
module tb_ysyx_23060332_ifu;

    logic        clk;
    logic        rst_n;
    logic        jump_flag;
    logic [31:0] jump_addr;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_o;
    logic [31:0] inst_addr;
    logic        fetch_err;

    logic        w_req_valid;
    logic [31:0] w_req_addr;
    logic        w_rsp_valid;
    logic [31:0] w_rsp_data;
    logic        w_inst_valid;
    logic [31:0] w_inst_o;
    logic [31:0] w_inst_addr;
    logic        w_fetch_err;
    logic        w_jump_flag;
    logic [31:0] w_jump_addr;
    logic        w_req_ready;
    logic        w_rsp_err;
    logic        w_inst_ready;

    int n_cmp;
    int n_bad;
    int lat;
    logic err_mode;

    ysyx_23060332_ifu u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .jump_flag      (jump_flag),
        .jump_addr      (jump_addr),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_o         (inst_o),
        .inst_addr      (inst_addr),
        .fetch_err      (fetch_err)
    );

    ysyx_23060332_ifu #(
        .RESET_PC (32'hFFFF_FFFC)
    ) u_wrap (
        .clk            (clk),
        .rst_n          (rst_n),
        .jump_flag      (w_jump_flag),
        .jump_addr      (w_jump_addr),
        .imem_req_valid (w_req_valid),
        .imem_req_ready (w_req_ready),
        .imem_req_addr  (w_req_addr),
        .imem_rsp_valid (w_rsp_valid),
        .imem_rsp_data  (w_rsp_data),
        .imem_rsp_err   (w_rsp_err),
        .inst_valid     (w_inst_valid),
        .inst_ready     (w_inst_ready),
        .inst_o         (w_inst_o),
        .inst_addr      (w_inst_addr),
        .fetch_err      (w_fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0010_0093 ^ {a[15:0], 16'h0000};
    endfunction

    // Memory for u_dut: response lat cycles after acceptance.
    task automatic mem_model();
        logic        acc;
        logic [31:0] a;
        logic        p1_v, p2_v;
        logic [31:0] p1_a, p2_a;
        logic        v;
        logic [31:0] ad;
        p1_v = 1'b0; p2_v = 1'b0; p1_a = '0; p2_a = '0;
        forever begin
            @(posedge clk);
            acc = imem_req_valid && imem_req_ready;
            a   = imem_req_addr;
            #1;
            p2_v = p1_v; p2_a = p1_a;
            p1_v = acc;  p1_a = a;
            v  = (lat == 1) ? p1_v : p2_v;
            ad = (lat == 1) ? p1_a : p2_a;
            imem_rsp_valid = v;
            imem_rsp_data  = v ? mem_word(ad) : 32'h0;
            imem_rsp_err   = v & err_mode;
        end
    endtask

    task automatic mem_wrap();
        logic acc;
        forever begin
            @(posedge clk);
            acc = w_req_valid && w_req_ready;
            #1;
            w_rsp_valid = acc;
            w_rsp_data  = 32'h0000_0013;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic reset_hold();
        rst_n      = 1'b0;
        jump_flag  = 1'b0;
        jump_addr  = 32'h0;
        inst_ready = 1'b0;
        err_mode   = 1'b0;
        lat        = 1;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        reset_hold();
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
        n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL rst_inst_valid: got %b want 0", inst_valid); end
        n_cmp++; if (fetch_err !== 1'b0) begin n_bad++; $display("FAIL rst_fetch_err: got %b want 0", fetch_err); end
        n_cmp++; if (inst_o !== 32'h0000_0013) begin n_bad++; $display("FAIL rst_inst_o: got %h want 00000013", inst_o); end
        n_cmp++; if (inst_addr !== 32'h8000_0000) begin n_bad++; $display("FAIL rst_inst_addr: got %h want 80000000", inst_addr); end
        n_cmp++; if (imem_req_addr !== 32'h8000_0000) begin n_bad++; $display("FAIL rst_req_addr: got %h want 80000000", imem_req_addr); end
        n_cmp++; if (w_req_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL rst_wrap_addr: got %h want fffffffc", w_req_addr); end
    endtask

    task automatic test_first_fetch();
        rst_n = 1'b1;
        tick();
        n_cmp++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL c1_req_valid: got %b want 1", imem_req_valid); end
        n_cmp++; if (imem_req_addr !== 32'h8000_0000) begin n_bad++; $display("FAIL c1_req_addr: got %h want 80000000", imem_req_addr); end
        tick();
        n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL c2_inst_valid: got %b want 0", inst_valid); end
        tick();
        n_cmp++; if (inst_valid !== 1'b1) begin n_bad++; $display("FAIL c3_inst_valid: got %b want 1", inst_valid); end
        n_cmp++; if (inst_o !== 32'h0010_0093) begin n_bad++; $display("FAIL c3_inst_o: got %h want 00100093", inst_o); end
        n_cmp++; if (inst_addr !== 32'h8000_0000) begin n_bad++; $display("FAIL c3_inst_addr: got %h want 80000000", inst_addr); end
    endtask

    task automatic test_back_pressure();
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (inst_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid[%0d]: got %b want 1", i, inst_valid); end
            n_cmp++; if (inst_o !== 32'h0010_0093) begin n_bad++; $display("FAIL bp_inst_o[%0d]: got %h want 00100093", i, inst_o); end
            n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL bp_req_valid[%0d]: got %b want 0", i, imem_req_valid); end
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        n_cmp++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL seq_req_valid: got %b want 1", imem_req_valid); end
        n_cmp++; if (imem_req_addr !== 32'h8000_0004) begin n_bad++; $display("FAIL seq_req_addr: got %h want 80000004", imem_req_addr); end
        tick();
        tick();
        n_cmp++; if (inst_o !== 32'h0014_0093) begin n_bad++; $display("FAIL seq_inst_o: got %h want 00140093", inst_o); end
        n_cmp++; if (inst_addr !== 32'h8000_0004) begin n_bad++; $display("FAIL seq_inst_addr: got %h want 80000004", inst_addr); end
    endtask

    task automatic test_redirect_wait();
        lat = 2;
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        tick();
        jump_flag = 1'b1;
        jump_addr = 32'h8000_0100;
        tick();
        jump_flag = 1'b0;
        n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL rw_valid_a: got %b want 0", inst_valid); end
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rw_req_a: got %b want 0", imem_req_valid); end
        tick();
        n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL rw_valid_b: got %b want 0", inst_valid); end
        n_cmp++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL rw_req_b: got %b want 1", imem_req_valid); end
        n_cmp++; if (imem_req_addr !== 32'h8000_0100) begin n_bad++; $display("FAIL rw_req_addr: got %h want 80000100", imem_req_addr); end
        tick();
        tick();
        n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL rw_valid_c: got %b want 0", inst_valid); end
        tick();
        n_cmp++; if (inst_valid !== 1'b1) begin n_bad++; $display("FAIL rw_valid_d: got %b want 1", inst_valid); end
        n_cmp++; if (inst_o !== 32'h0110_0093) begin n_bad++; $display("FAIL rw_inst_o: got %h want 01100093", inst_o); end
        n_cmp++; if (inst_addr !== 32'h8000_0100) begin n_bad++; $display("FAIL rw_inst_addr: got %h want 80000100", inst_addr); end
    endtask

    task automatic test_jump_out();
        lat = 1;
        inst_ready = 1'b1;
        jump_flag  = 1'b1;
        jump_addr  = 32'h8000_0040;
        tick();
        inst_ready = 1'b0;
        jump_flag  = 1'b0;
        n_cmp++; if (imem_req_addr !== 32'h8000_0040) begin n_bad++; $display("FAIL jo_req_addr: got %h want 80000040", imem_req_addr); end
        tick();
        tick();
        n_cmp++; if (inst_o !== 32'h0050_0093) begin n_bad++; $display("FAIL jo_inst_o: got %h want 00500093", inst_o); end
        n_cmp++; if (inst_addr !== 32'h8000_0040) begin n_bad++; $display("FAIL jo_inst_addr: got %h want 80000040", inst_addr); end
    endtask

    task automatic test_flush_out();
        jump_flag = 1'b1;
        jump_addr = 32'h8000_0200;
        tick();
        jump_flag = 1'b0;
        n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL fl_valid: got %b want 0", inst_valid); end
        n_cmp++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL fl_req_valid: got %b want 1", imem_req_valid); end
        n_cmp++; if (imem_req_addr !== 32'h8000_0200) begin n_bad++; $display("FAIL fl_req_addr: got %h want 80000200", imem_req_addr); end
    endtask

    task automatic test_fault();
        reset_hold();
        rst_n    = 1'b1;
        err_mode = 1'b1;
        repeat (3) tick();
        n_cmp++; if (fetch_err !== 1'b1) begin n_bad++; $display("FAIL flt_err: got %b want 1", fetch_err); end
        n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL flt_valid: got %b want 0", inst_valid); end
        err_mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL flt_req[%0d]: got %b want 0", i, imem_req_valid); end
            n_cmp++; if (fetch_err !== 1'b1) begin n_bad++; $display("FAIL flt_sticky[%0d]: got %b want 1", i, fetch_err); end
        end
        reset_hold();
        n_cmp++; if (fetch_err !== 1'b0) begin n_bad++; $display("FAIL flt_clear: got %b want 0", fetch_err); end
        rst_n = 1'b1;
        repeat (3) tick();
        n_cmp++; if (inst_valid !== 1'b1) begin n_bad++; $display("FAIL flt_refetch: got %b want 1", inst_valid); end
        n_cmp++; if (inst_o !== 32'h0010_0093) begin n_bad++; $display("FAIL flt_inst_o: got %h want 00100093", inst_o); end
    endtask

    task automatic test_misalign();
        jump_flag = 1'b1;
        jump_addr = 32'h8000_0002;
        tick();
        jump_flag = 1'b0;
        n_cmp++; if (fetch_err !== 1'b1) begin n_bad++; $display("FAIL mis_err: got %b want 1", fetch_err); end
        n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL mis_valid: got %b want 0", inst_valid); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL mis_req[%0d]: got %b want 0", i, imem_req_valid); end
            tick();
        end
    endtask

    task automatic test_wrap();
        reset_hold();
        rst_n = 1'b1;
        tick();
        n_cmp++; if (w_req_valid !== 1'b1) begin n_bad++; $display("FAIL wr_req1_valid: got %b want 1", w_req_valid); end
        n_cmp++; if (w_req_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wr_req1_addr: got %h want fffffffc", w_req_addr); end
        tick();
        tick();
        n_cmp++; if (w_inst_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wr_inst_addr: got %h want fffffffc", w_inst_addr); end
        tick();
        n_cmp++; if (w_req_valid !== 1'b1) begin n_bad++; $display("FAIL wr_req2_valid: got %b want 1", w_req_valid); end
        n_cmp++; if (w_req_addr !== 32'h0000_0000) begin n_bad++; $display("FAIL wr_req2_addr: got %h want 00000000", w_req_addr); end
    endtask

    initial begin
        n_cmp          = 0;
        n_bad          = 0;
        lat            = 1;
        err_mode       = 1'b0;
        rst_n          = 1'b0;
        jump_flag      = 1'b0;
        jump_addr      = 32'h0;
        inst_ready     = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        imem_rsp_err   = 1'b0;
        w_jump_flag    = 1'b0;
        w_jump_addr    = 32'h0;
        w_req_ready    = 1'b1;
        w_rsp_valid    = 1'b0;
        w_rsp_data     = 32'h0;
        w_rsp_err      = 1'b0;
        w_inst_ready   = 1'b1;
        fork
            mem_model();
            mem_wrap();
        join_none
        test_reset();
        test_first_fetch();
        test_back_pressure();
        test_redirect_wait();
        test_jump_out();
        test_flush_out();
        test_fault();
        test_misalign();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ysyx_23060332_ifu.md
# ysyx_23060332_ifu

Instruction fetch unit for the NPC core: owns the PC, issues one instruction-memory read per instruction over a valid/ready request channel and accepts a valid-only response channel. It presents the fetched word plus its address to the decode stage through a valid/ready handshake. It also applies redirects (`jal`/`jalr`/branch targets) fed back from the execute stage. It sits directly upstream of the IDU, driving `inst_i`/`inst_addr`.

## Interface
- `RESET_PC`, default `32'h8000_0000`: first fetch address after reset.
- `clk`  in  1  core clock, all state on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `jump_flag`  in  1  redirect request from EXU.
- `jump_addr`  in  32  redirect target.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_req_addr`  out  32  fetch address.
- `imem_rsp_valid`  in  1  read data valid; memory always accepts no back-pressure.
- `imem_rsp_data`  in  32  instruction word.
- `imem_rsp_err`  in  1  bus error on this response.
- `inst_valid`  out  1  instruction available to IDU.
- `inst_ready`  in  1  IDU/EXU consume the instruction this cycle.
- `inst_o`  out  32  instruction word to IDU.
- `inst_addr`  out  32  PC of `inst_o`.
- `fetch_err`  out  1  sticky fault flag.

## Operation
- Registers: `pc`, `req_addr`, `inst_o`, `inst_addr`, `drop`, `state`.
- The FSM has five states. Each state's behaviour and transitions are as follows:
  - **IDLE**: one cycle after reset. Moves to REQ and loads `req_addr <= pc`.
  - **REQ**: `imem_req_valid=1`, `imem_req_addr=req_addr`. The address is held stable until `imem_req_ready`. On `imem_req_ready` the FSM moves to WAIT.
  - **WAIT**: waits for `imem_rsp_valid`.
    - If `drop=0` and `imem_rsp_err=0`, it captures `inst_o <= imem_rsp_data` and `inst_addr <= req_addr`, then moves to OUT.
    - If `drop=1`, it discards the data, clears `drop`, loads `req_addr <= pc`, and moves to REQ.
    - If `imem_rsp_err=1` and `drop=0`, it moves to ERR.
  - **OUT**: `inst_valid=1`. On `inst_ready`:
    - without a jump, `pc <= pc+4`;
    - with a jump, `pc <= jump_addr`.
    - In both cases it loads `req_addr` with the new pc and moves to REQ.
  - **ERR**: sets `fetch_err=1`. Every output request is 0. The FSM stays here until reset.
- Redirect (`jump_flag=1`) is handled per state:
  - In REQ or WAIT, `pc <= jump_addr` and `drop <= 1`. The in-flight request still completes and its response is discarded.
  - In OUT without `inst_ready`, the held instruction is flushed: `inst_valid` falls next cycle, `req_addr <= jump_addr`, `pc <= jump_addr`, and the FSM moves to REQ.
- Misaligned redirect (`jump_addr[1:0]!=0`): ERR, no fetch issued.
- `pc+4` wraps modulo 2^32 (`32'hFFFF_FFFC` → `0`). No overflow detection.
- `imem_rsp_valid` outside WAIT is a protocol violation and is ignored.

## Timing
- Reset values (held while `rst_n=0`):
  - `pc = req_addr = inst_addr = RESET_PC`
  - `inst_o = 32'h0000_0013` (NOP)
  - `imem_req_valid = inst_valid = fetch_err = 0`
  - `drop = 0`, `state = IDLE`
- Reset asserted mid-transaction aborts at the next edge. Any later response is ignored because the FSM restarts in IDLE.
- Cycle 0 is the first edge with `rst_n=1`. The sequence is IDLE at c0, REQ at c1.
- Zero-wait memory (ready=1, response one cycle after acceptance):
  - request accepted at c1;
  - `rsp_valid` at c2;
  - `inst_valid` at c3.
- Steady state with `inst_ready` tied high: one instruction per 3 cycles.
- Memory response is never same-cycle with request acceptance; the minimum gap is 1 cycle.
- `inst_o` and `inst_addr` are stable while `inst_valid=1` and `inst_ready=0`.
- All outputs are registered except `imem_req_valid` and `inst_valid`, which are decoded from `state` (glitch-free, state is one-hot).

## Structure
- The shared define file gets the following additions:
  - `` `ResetPC`` default;
  - `` `INST_NOP`` (already used by decode);
  - FSM state encodings `IFU_IDLE`/`IFU_REQ`/`IFU_WAIT`/`IFU_OUT`/`IFU_ERR`;
  - reuse of `` `InstBus``/`` `InstAddrBus``.
- One sub-module, `ysyx_23060332_pc_reg`: PC register with reset value, `+4` advance, redirect load, and misalignment flag. The FSM and handshake logic stay in the top.

## Test plan
- **Reset and first fetch.** Hold `rst_n=0` 3 cycles, release, memory ready=1, 1-cycle latency, data `32'h0010_0093`. Required response:
  - `imem_req_addr=32'h8000_0000` at c1;
  - `inst_valid=1` at c3 with `inst_o=32'h0010_0093`, `inst_addr=32'h8000_0000`.
- **Sequential run with back-pressure.** `inst_ready` low for 4 cycles in OUT. Required response: `inst_o` held stable; the next request address is `32'h8000_0004` after the handshake.
- **Redirect during WAIT.** `jump_flag=1`, `jump_addr=32'h8000_0100` while a response is pending. Required response: the pending response is discarded and not presented; the next request is `32'h8000_0100`.
- **Jump with handshake in OUT.** `inst_ready=1` and `jump_flag=1` with `jump_addr=32'h8000_0040`. Required response: the next request address is `32'h8000_0040`, not +4.
- **Memory fault and misalignment.** `imem_rsp_err=1` → `fetch_err=1` sticky and no further requests; a fresh reset clears it. Separately, redirect to `32'h8000_0002` → ERR.
- **Wrap-around.** `RESET_PC=32'hFFFF_FFFC` → the second fetch address is `32'h0000_0000`.
